// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module : pc_sequencer
// Brief  : Program-counter sequencer: next-PC select, stall, halt/resume,
//          misaligned-target trap, retired-instruction counter.
//          Optional return-address stack enabled by defining PC_SEQ_RAS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              CNT_W        = 32,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             resume,
    input  logic [1:0]       pc_sel,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_offset,
    input  logic [25:0]      jump_target,
    input  logic [XLEN-1:0]  reg_target,
    input  logic             link,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic [XLEN-1:0]  link_addr,
    output logic             fetch_valid,
    output logic [1:0]       state,
    output logic             misaligned_trap,
    output logic [XLEN-1:0]  trap_target,
    output logic [CNT_W-1:0] instr_count,
    output logic             ras_mispredict
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10,
        ST_TRAP = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_link_addr;
    logic [XLEN-1:0]  r_trap_target;
    logic [CNT_W-1:0] r_count;

    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_jump_pc;
    logic [XLEN-1:0]  w_pc_next;
    logic             w_misaligned;
    logic             w_update;
    logic             w_trap_enter;
    logic             w_recover;

    assign w_pc_plus4 = r_pc + XLEN'(4);

    // Region-relative jump keeps the upper bits of pc+4 above bit 27.
    generate
        if (XLEN > 28) begin : g_jump_region
            assign w_jump_pc = {w_pc_plus4[XLEN-1:28], jump_target, 2'b00};
        end else begin : g_jump_flat
            assign w_jump_pc = {jump_target, 2'b00};
        end
    endgenerate

    always_comb begin
        w_pc_next = w_pc_plus4;
        case (pc_sel)
            2'b01:   w_pc_next = branch_taken ? (w_pc_plus4 + (branch_offset << 2)) : w_pc_plus4;
            2'b10:   w_pc_next = w_jump_pc;
            2'b11:   w_pc_next = reg_target;
            default: w_pc_next = w_pc_plus4;
        endcase
    end

    assign w_misaligned = (w_pc_next[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_update     = 1'b0;
        w_trap_enter = 1'b0;
        w_recover    = 1'b0;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                // Trap beats halt, halt beats stall.
                if (w_misaligned) begin
                    w_state_nxt  = ST_TRAP;
                    w_trap_enter = 1'b1;
                end else if (halt_req) begin
                    w_state_nxt = ST_HALT;
                end else if (!stall) begin
                    w_update = 1'b1;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_TRAP: begin
                if (resume) begin
                    w_state_nxt = ST_RUN;
                    w_recover   = 1'b1;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_VECTOR;
            r_link_addr   <= '0;
            r_trap_target <= '0;
            r_count       <= '0;
        end else begin
            if (w_update) begin
                r_pc <= w_pc_next;
                if (r_count != '1) begin
                    r_count <= r_count + CNT_W'(1);
                end
                if (link) begin
                    r_link_addr <= w_pc_plus4;
                end
            end
            if (w_recover) begin
                r_pc <= RESET_VECTOR;
            end
            if (w_trap_enter) begin
                r_trap_target <= w_pc_next;
            end
        end
    end

    assign pc              = r_pc;
    assign pc_plus4        = w_pc_plus4;
    assign link_addr       = r_link_addr;
    assign fetch_valid     = (r_state == ST_RUN);
    assign state           = r_state;
    assign misaligned_trap = (r_state == ST_TRAP);
    assign trap_target     = r_trap_target;
    assign instr_count     = r_count;

`ifdef PC_SEQ_RAS_EN
    localparam int                 c_ptr_w = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int                 c_cnt_w = $clog2(RAS_DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(RAS_DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(RAS_DEPTH);

    logic [XLEN-1:0]    r_ras [RAS_DEPTH];
    logic [c_ptr_w-1:0] r_top;
    logic [c_cnt_w-1:0] r_ras_cnt;
    logic               r_mispredict;
    logic               w_pop;
    logic               w_push;
    logic [c_ptr_w-1:0] w_top_dec;
    logic [c_ptr_w-1:0] w_top_mid;
    logic [c_ptr_w-1:0] w_top_inc;
    logic [c_cnt_w-1:0] w_cnt_mid;

    // Circular stack: r_top is the next free slot; when full it is also the oldest entry.
    assign w_pop     = w_update && (pc_sel == 2'b11) && (r_ras_cnt != '0);
    assign w_push    = w_update && link;
    assign w_top_dec = (r_top == '0) ? c_last : (r_top - c_ptr_w'(1));
    assign w_top_mid = w_pop ? w_top_dec : r_top;
    assign w_top_inc = (w_top_mid == c_last) ? '0 : (w_top_mid + c_ptr_w'(1));
    assign w_cnt_mid = w_pop ? (r_ras_cnt - c_cnt_w'(1)) : r_ras_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_top        <= '0;
            r_ras_cnt    <= '0;
            r_mispredict <= 1'b0;
        end else begin
            r_mispredict <= w_pop && (r_ras[w_top_dec] != reg_target);
            if (w_push) begin
                r_top     <= w_top_inc;
                r_ras_cnt <= (w_cnt_mid == c_full) ? c_full : (w_cnt_mid + c_cnt_w'(1));
            end else begin
                r_top     <= w_top_mid;
                r_ras_cnt <= w_cnt_mid;
            end
        end
    end

    // Entries need no reset: the occupancy count alone marks which slots are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[w_top_mid] <= w_pc_plus4;
        end
    end

    assign ras_mispredict = r_mispredict;
`else
    logic w_unused_ras;
    assign w_unused_ras   = (RAS_DEPTH > 0);
    assign ras_mispredict = 1'b0;
`endif

endmodule
`default_nettype wire
